cga_composite_decoder: RTL and testbench



---
 rtl/cga_composite_decoder_if.sv | 27 ++
 rtl/cga_composite_decoder.sv | 170 +++++++++++++++++
 tb/tb_cga_composite_decoder.sv | 256 +++++++++++++++++++++++++
 3 files changed

// File: rtl/cga_composite_decoder_if.sv
`timescale 1ns/1ps
`default_nettype none
// +----------------------------------------------------------------------+
// | cga_composite_decoder_if : sample-stream and decoded-output bundle   |
// | Revision 1.0                                                         |
// +----------------------------------------------------------------------+
interface cga_composite_decoder_if;
  logic       pix_en;
  logic [6:0] comp_video;
  logic       hsync_out;
  logic       vsync_out;
  logic [1:0] burst_phase;
  logic       color_present;
  logic [8:0] luma;

  modport master (
    output pix_en, comp_video,
    input  hsync_out, vsync_out, burst_phase, color_present, luma
  );

  modport slave (
    input  pix_en, comp_video,
    output hsync_out, vsync_out, burst_phase, color_present, luma
  );
endinterface

`default_nettype wire

// File: rtl/cga_composite_decoder.sv
`timescale 1ns/1ps
`default_nettype none
// +----------------------------------------------------------------------+
// | cga_composite_decoder : sync separator, burst phase lock, 4-tap luma |
// | Revision 1.0                                                         |
// +----------------------------------------------------------------------+
module cga_composite_decoder #(
  parameter int SYNC_MIN    = 8,
  parameter int HSYNC_MAX   = 100,
  parameter int VSYNC_MIN   = 200,
  parameter int VSYNC_END   = 128,
  parameter int BURST_START = 16,
  parameter int BURST_LEN   = 32,
  parameter int BURST_THR   = 43
) (
  input  wire logic                clk,
  input  wire logic                rst_n,
  cga_composite_decoder_if.slave   io_bus
);

  typedef enum logic [1:0] {
    S_ACTIVE = 2'd0,
    S_HSYNC  = 2'd1,
    S_VSYNC  = 2'd2
  } sync_t;

  typedef enum logic [1:0] {
    B_IDLE   = 2'd0,
    B_WAIT   = 2'd1,
    B_WINDOW = 2'd2
  } burst_t;

  localparam logic [9:0] c_RUN_MAX   = 10'd1023;
  localparam logic [9:0] c_SYNC_MIN  = 10'(SYNC_MIN);
  localparam logic [9:0] c_HSYNC_MAX = 10'(HSYNC_MAX);
  localparam logic [9:0] c_VSYNC_MIN = 10'(VSYNC_MIN);
  localparam logic [9:0] c_VSYNC_END = 10'(VSYNC_END);
  localparam logic [9:0] c_WAIT_LAST = 10'(BURST_START - 1);
  localparam logic [9:0] c_WIN_LAST  = 10'(BURST_LEN - 1);
  localparam logic [6:0] c_THR       = 7'(BURST_THR);

  logic [6:0] r_s0, r_s1, r_s2, r_s3;
  logic [9:0] r_low_run, r_high_run, r_pulse_len;
  logic [1:0] r_phase;
  logic [8:0] r_luma;
  sync_t      r_sync;
  burst_t     r_burst;
  logic [9:0] r_bcnt;
  logic       r_seen;
  logic [1:0] r_hold;
  logic       r_color;
  logic [1:0] r_burst_phase;

  logic w_low, w_enter_sync, w_trail, w_arm, w_rise;

  assign w_low        = (r_s0 == 7'd0);
  assign w_enter_sync = (r_sync == S_ACTIVE) && (r_low_run >= c_SYNC_MIN);
  assign w_trail      = (r_sync == S_HSYNC) && (r_high_run != 10'd0);
  // r_pulse_len holds the length of the low run that just ended
  assign w_arm        = w_trail && (r_pulse_len <= c_HSYNC_MAX);
  assign w_rise       = (r_s0 >= c_THR) && (r_s1 < c_THR);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s0        <= '0;
      r_s1        <= '0;
      r_s2        <= '0;
      r_s3        <= '0;
      r_low_run   <= '0;
      r_high_run  <= '0;
      r_pulse_len <= '0;
      r_phase     <= '0;
      r_luma      <= '0;
    end else if (io_bus.pix_en) begin
      r_s0    <= io_bus.comp_video;
      r_s1    <= r_s0;
      r_s2    <= r_s1;
      r_s3    <= r_s2;
      r_phase <= r_phase + 2'd1;
      r_luma  <= 9'(r_s0) + 9'(r_s1) + 9'(r_s2) + 9'(r_s3);
      if (w_low) begin
        if (r_low_run != c_RUN_MAX)
          r_low_run <= r_low_run + 10'd1;
        r_high_run <= '0;
      end else begin
        if (r_high_run != c_RUN_MAX)
          r_high_run <= r_high_run + 10'd1;
        if (r_low_run != 10'd0)
          r_pulse_len <= r_low_run;
        r_low_run <= '0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync <= S_ACTIVE;
    end else if (io_bus.pix_en) begin
      case (r_sync)
        S_ACTIVE: if (w_enter_sync) r_sync <= S_HSYNC;
        S_HSYNC: begin
          if (r_low_run >= c_VSYNC_MIN) r_sync <= S_VSYNC;
          else if (w_trail)             r_sync <= S_ACTIVE;
        end
        // serration gaps are shorter than VSYNC_END and are ridden through
        S_VSYNC:  if (r_high_run >= c_VSYNC_END) r_sync <= S_ACTIVE;
        default:  r_sync <= S_ACTIVE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_burst       <= B_IDLE;
      r_bcnt        <= '0;
      r_seen        <= 1'b0;
      r_hold        <= '0;
      r_color       <= 1'b0;
      r_burst_phase <= '0;
    end else if (io_bus.pix_en) begin
      if (w_arm) begin
        r_burst <= B_WAIT;
        r_bcnt  <= '0;
        r_seen  <= 1'b0;
      end else if (w_enter_sync || (r_sync != S_ACTIVE)) begin
        r_burst <= B_IDLE;
        r_bcnt  <= '0;
        r_seen  <= 1'b0;
      end else begin
        case (r_burst)
          B_WAIT: begin
            if (r_bcnt == c_WAIT_LAST) begin
              r_burst <= B_WINDOW;
              r_bcnt  <= '0;
            end else begin
              r_bcnt <= r_bcnt + 10'd1;
            end
          end
          B_WINDOW: begin
            if (w_rise && !r_seen) begin
              r_seen <= 1'b1;
              r_hold <= r_phase;
            end
            // the final window sample still counts toward the result
            if (r_bcnt == c_WIN_LAST) begin
              r_burst <= B_IDLE;
              r_bcnt  <= '0;
              r_seen  <= 1'b0;
              r_color <= r_seen | w_rise;
              if (r_seen)      r_burst_phase <= r_hold;
              else if (w_rise) r_burst_phase <= r_phase;
            end else begin
              r_bcnt <= r_bcnt + 10'd1;
            end
          end
          default: r_burst <= B_IDLE;
        endcase
      end
    end
  end

  assign io_bus.hsync_out     = (r_sync == S_HSYNC);
  assign io_bus.vsync_out     = (r_sync == S_VSYNC);
  assign io_bus.color_present = r_color;
  assign io_bus.burst_phase   = r_burst_phase;
  assign io_bus.luma          = (r_sync == S_ACTIVE) ? r_luma : 9'd0;

endmodule

`default_nettype wire

// File: tb/tb_cga_composite_decoder.sv
`timescale 1ns/1ps
`default_nettype none
// tb_cga_composite_decoder: random line/field stimulus against a sample-history
// reference model; a monitor pops expected outputs on every pix_en.
module tb_cga_composite_decoder;

  localparam int SYNC_MIN    = 8;
  localparam int HSYNC_MAX   = 100;
  localparam int VSYNC_MIN   = 200;
  localparam int VSYNC_END   = 128;
  localparam int BURST_START = 16;
  localparam int BURST_LEN   = 32;
  localparam int BURST_THR   = 43;
  localparam int MAXT        = 30000;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  cga_composite_decoder_if bus();

  cga_composite_decoder #(
    .SYNC_MIN(SYNC_MIN), .HSYNC_MAX(HSYNC_MAX), .VSYNC_MIN(VSYNC_MIN),
    .VSYNC_END(VSYNC_END), .BURST_START(BURST_START), .BURST_LEN(BURST_LEN),
    .BURST_THR(BURST_THR)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .io_bus(bus)
  );

  typedef struct packed {
    logic       hs;
    logic       vs;
    logic       cp;
    logic [1:0] bp;
    logic [8:0] luma;
  } exp_t;

  exp_t exp_q[$];
  int   total = 0;
  int   bad   = 0;

  // Reference model: hist[k] is the sample taken on the k-th pix_en after
  // reset; hist[0] is the zero the input register holds out of reset.
  int       hist [0:MAXT];
  int       t;
  int       m_state;   // 0 active, 1 hsync, 2 vsync
  logic     m_cp;
  logic [1:0] m_bp;
  bit       win_pend;
  int       win_arm;

  function automatic int zrun(int k);
    int n = 0;
    while (k >= 0 && hist[k] == 0 && n < 1023) begin n++; k--; end
    return n;
  endfunction

  function automatic int hrun(int k);
    int n = 0;
    while (k >= 0 && hist[k] != 0 && n < 1023) begin n++; k--; end
    return n;
  endfunction

  function automatic void model_reset();
    t = 0; hist[0] = 0; m_state = 0; m_cp = 1'b0; m_bp = 2'd0; win_pend = 1'b0; win_arm = 0;
  endfunction

  function automatic void model_step(int lvl);
    int   lr, hr, first;
    bit   arm;
    exp_t e;
    e = '0;
    arm = 1'b0;
    if (t < MAXT) t++;
    hist[t] = lvl;
    // decisions see run lengths through two pipeline stages
    lr = zrun(t - 2);
    hr = hrun(t - 2);
    case (m_state)
      0: if (lr >= SYNC_MIN) m_state = 1;
      1: if (lr >= VSYNC_MIN) m_state = 2;
         else if (hr >= 1) begin
           m_state = 0;
           arm = (zrun(t - 2 - hr) <= HSYNC_MAX);
         end
      default: if (hr >= VSYNC_END) m_state = 0;
    endcase
    if (arm) begin
      win_pend = 1'b1;
      win_arm  = t;
    end else if (win_pend && m_state != 0) begin
      win_pend = 1'b0;
    end else if (win_pend && t == win_arm + BURST_START + BURST_LEN) begin
      first = -1;
      for (int k = win_arm + BURST_START; k < win_arm + BURST_START + BURST_LEN; k++)
        if (first < 0 && hist[k] >= BURST_THR && hist[k-1] < BURST_THR) first = k;
      m_cp = (first >= 0);
      if (first >= 0) m_bp = 2'(first % 4);
      win_pend = 1'b0;
    end
    e.hs = (m_state == 1);
    e.vs = (m_state == 2);
    e.cp = m_cp;
    e.bp = m_bp;
    if (m_state == 0)
      for (int d = 1; d <= 4; d++)
        if (t - d >= 0) e.luma = e.luma + 9'(hist[t-d]);
    exp_q.push_back(e);
  endfunction

  task automatic chk(input string nm, input int act, input int req);
    total++;
    if (act != req) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (tick %0d)", nm, act, req, t);
    end
  endtask

  // Monitor
  initial begin : mon
    exp_t e;
    forever begin
      @(posedge clk);
      if (rst_n && bus.pix_en) begin
        #1;
        if (exp_q.size() == 0) begin
          total++; bad++;
          $display("FAIL scoreboard: got output with no expectation (tick %0d)", t);
        end else begin
          e = exp_q.pop_front();
          chk("hsync_out",     int'(bus.hsync_out),     int'(e.hs));
          chk("vsync_out",     int'(bus.vsync_out),     int'(e.vs));
          chk("color_present", int'(bus.color_present), int'(e.cp));
          chk("burst_phase",   int'(bus.burst_phase),   int'(e.bp));
          chk("luma",          int'(bus.luma),          int'(e.luma));
        end
      end
    end
  end

  task automatic tick(input int lvl);
    @(negedge clk);
    bus.comp_video = 7'(lvl);
    bus.pix_en     = 1'b1;
    model_step(lvl);
    @(negedge clk);
    bus.pix_en     = 1'b0;
    bus.comp_video = 7'($urandom);
    if ($urandom_range(0, 7) == 0) @(negedge clk);
  endtask

  task automatic run(input int n, input int lvl);
    for (int i = 0; i < n; i++) tick(lvl);
  endtask

  task automatic run_rand(input int n);
    for (int i = 0; i < n; i++) tick(int'($urandom_range(1, 127)));
  endtask

  // Sync pulse, porch, 40 samples of burst (rising where tick index = p mod 4), active video
  task automatic burst_run(input bit burst, input int p, input int hi, input int lo, input int n);
    for (int i = 0; i < n; i++) begin
      int k;
      k = t + 1;
      tick((burst && ((k + 4 - p) % 4) < 2) ? hi : ((burst) ? lo : 29));
    end
  endtask

  task automatic line(input int plen, input bit burst, input int p, input int tail,
                      input int hi = 57, input int lo = 29);
    run(plen, 0);
    run(16, 29);
    burst_run(burst, p, hi, lo, 40);
    run_rand(tail);
  endtask

  task automatic chk_zero_outputs(input string tag);
    chk({tag, " hsync_out"},     int'(bus.hsync_out),     0);
    chk({tag, " vsync_out"},     int'(bus.vsync_out),     0);
    chk({tag, " color_present"}, int'(bus.color_present), 0);
    chk({tag, " burst_phase"},   int'(bus.burst_phase),   0);
    chk({tag, " luma"},          int'(bus.luma),          0);
  endtask

  initial begin : watchdog
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached at tick %0d", t);
    $fatal(1, "watchdog");
  end

  initial begin : drive
    bus.pix_en     = 1'b0;
    bus.comp_video = 7'd0;
    model_reset();
    #12;
    chk_zero_outputs("reset");
    @(negedge clk);
    rst_n = 1'b1;

    run(300, 29);
    line(64, 1'b1, 2, 300);                 // burst locks at phase 2
    line(64, 1'b0, 0, 300);                 // black-and-white: phase held
    for (int i = 0; i < 4; i++)
      line(int'($urandom_range(SYNC_MIN, HSYNC_MAX)), 1'b1, int'($urandom_range(0, 3)),
           int'($urandom_range(150, 300)), int'($urandom_range(BURST_THR, 127)),
           int'($urandom_range(1, BURST_THR - 1)));
    line(64, 1'b1, 1, 200, BURST_THR, BURST_THR - 1);
    line(5, 1'b1, 3, 200);                  // too short to be sync
    line(7, 1'b1, 0, 200);
    line(8, 1'b1, 0, 200);
    line(100, 1'b1, 3, 200);
    line(101, 1'b1, 2, 200);                // over HSYNC_MAX: discarded
    line(150, 1'b1, 1, 300);
    run(60, 99);                            // luma 396

    run(250, 0);                            // vertical sync with serrations
    for (int i = 0; i < 6; i++) begin
      run(64, 29);
      run(848, 0);
    end
    run(200, 29);
    line(64, 1'b1, 0, 200);
    run(1100, 0);                           // run counters saturate
    run(200, 29);
    line(64, 1'b1, 3, 200);

    line(64, 1'b1, 1, 200);
    run(64, 0);                             // reset in the middle of the window
    run(16, 29);
    burst_run(1'b1, 2, 57, 29, 20);
    #2 rst_n = 1'b0;
    #1;
    chk_zero_outputs("async reset");
    exp_q.delete();
    model_reset();
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    run(40, 29);
    line(64, 1'b0, 0, 200);
    line(64, 1'b1, 2, 100);

    repeat (4) @(negedge clk);
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL drain: %0d expected outputs never presented", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
